// File: rtl/md5_pkg.sv
// Shared constants, state type and helpers for the single-block MD5 engine.
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } md5_state_e;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Indexed by {round, step mod 4}.
  localparam logic [4:0] SHIFT_TABLE [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    return SHIFT_TABLE[{i[5:4], i[1:0]}];
  endfunction

  // Message word index; arithmetic is done in 4 bits so mod 16 is free.
  function automatic logic [3:0] msg_index(input logic [5:0] i);
    logic [3:0] g;
    case (i[5:4])
      2'd0:    g = i[3:0];
      2'd1:    g = i[3:0] * 4'd5 + 4'd1;
      2'd2:    g = i[3:0] * 4'd3 + 4'd5;
      default: g = i[3:0] * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, add chain and rotate.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [5:0]  i,
  input  logic [31:0] m_word,
  input  logic [31:0] k,
  input  logic [4:0]  s,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [63:0] rot;

  always_comb begin
    case (i[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    sum = a + f + k + m_word;
    // Upper half of the shifted doubled word is the 32-bit left rotate.
    rot = {sum, sum} << s;
    a_next = d;
    b_next = b + rot[63:32];
    c_next = b;
    d_next = c;
  end

endmodule

// File: rtl/md5_hash_engine.sv
// Iterative single-block MD5 core, one step per clock, 65-clock latency.
// Optional width rejection with err strobe: define MD5_WIDTH_CHECK_EN.
module md5_hash_engine
  import md5_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] msg_in,
  input  logic [7:0]   msg_in_width,
  input  logic         msg_in_valid,
  output logic [127:0] msg_output,
  output logic         msg_out_valid,
  output logic         ready,
  output logic         err
);

  md5_state_e  state_q, state_d;
  logic [5:0]  step_q;
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [31:0] a_nx, b_nx, c_nx, d_nx;
  logic [31:0] m_q   [16];
  logic [31:0] m_pad [16];
  logic [7:0]  blk   [64];
  logic [4:0]  n_bytes;
  logic        width_bad;
  logic        accept;

`ifdef MD5_WIDTH_CHECK_EN
  assign width_bad = (msg_in_width[2:0] != 3'd0) || (msg_in_width > 8'(8 * MAX_BYTES));
  assign n_bytes   = msg_in_width[7:3];

  always_ff @(posedge clock) begin
    if (reset) err <= 1'b0;
    else       err <= (state_q == ST_IDLE) && msg_in_valid && width_bad;
  end
`else
  localparam logic [4:0] MAX_B = 5'(MAX_BYTES);
  logic unused_width_lsb;

  assign unused_width_lsb = ^msg_in_width[2:0];
  assign width_bad = 1'b0;
  assign n_bytes   = (msg_in_width[7:3] > MAX_B) ? MAX_B : msg_in_width[7:3];
  assign err       = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && msg_in_valid && !width_bad;

  // Padded block; the length field uses the whole-byte width actually hashed.
  always_comb begin
    for (int unsigned b = 0; b < 64; b++) blk[b] = 8'h00;
    for (int unsigned b = 0; b < 16; b++) begin
      if (b < 32'(n_bytes)) blk[b] = msg_in[127 - 8*b -: 8];
    end
    blk[{1'b0, n_bytes}] = 8'h80;
    blk[56] = {n_bytes, 3'b000};
    for (int unsigned j = 0; j < 16; j++)
      m_pad[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
  end

  md5_step u_step (
    .a      (a_q),
    .b      (b_q),
    .c      (c_q),
    .d      (d_q),
    .i      (step_q),
    .m_word (m_q[msg_index(step_q)]),
    .k      (K_TABLE[step_q]),
    .s      (shift_amt(step_q)),
    .a_next (a_nx),
    .b_next (b_nx),
    .c_next (c_nx),
    .d_next (d_nx)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = ~reset;
        if (accept) state_d = ST_ROUND;
      end
      ST_ROUND: if (step_q == 6'd63) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      msg_output    <= '0;
      msg_out_valid <= 1'b0;
      step_q        <= '0;
    end else begin
      msg_out_valid <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            m_q    <= m_pad;
            a_q    <= IV_A;
            b_q    <= IV_B;
            c_q    <= IV_C;
            d_q    <= IV_D;
            step_q <= '0;
          end
        end
        ST_ROUND: begin
          a_q    <= a_nx;
          b_q    <= b_nx;
          c_q    <= c_nx;
          d_q    <= d_nx;
          step_q <= step_q + 6'd1;
        end
        ST_DONE: begin
          msg_output    <= {bswap32(a_q + IV_A), bswap32(b_q + IV_B),
                            bswap32(c_q + IV_C), bswap32(d_q + IV_D)};
          msg_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_hash_engine.sv
// Directed plus randomized bench for md5_hash_engine with a behavioural MD5 model.
module tb_md5_hash_engine;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] msg_in;
  logic [7:0]   msg_in_width;
  logic         msg_in_valid;
  logic [127:0] msg_output;
  logic         msg_out_valid;
  logic         ready;
  logic         err;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [127:0] MSG_A   = {8'h61, 120'h0};
  localparam logic [127:0] MSG_ABC = {24'h616263, 104'h0};
  localparam logic [127:0] MSG_MD  = {"message digest", 16'h0};
  localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] DIG_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
  localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] DIG_MD    = 128'hf96b697d7cb7938d525a2f31aaf161d0;

  md5_hash_engine #(.MAX_BYTES(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .msg_in        (msg_in),
    .msg_in_width  (msg_in_width),
    .msg_in_valid  (msg_in_valid),
    .msg_output    (msg_output),
    .msg_out_valid (msg_out_valid),
    .ready         (ready),
    .err           (err)
  );

  always #5 clock = ~clock;

  // RFC 1321 MD5 of the first n bytes of msg, K derived from the sine definition.
  function automatic logic [127:0] md5_ref(input logic [127:0] msg, input int n);
    logic [7:0]  blk [64];
    logic [31:0] w [16];
    logic [31:0] h [4];
    logic [31:0] a, b, c, d, f, t, kk, tmp;
    int unsigned sh [16];
    int unsigned amt;
    int g;
    real x;
    logic [127:0] out;
    sh = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    h  = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < n; i++) blk[i] = msg[127 - 8*i -: 8];
    blk[n]  = 8'h80;
    blk[56] = 8'(n * 8);
    for (int j = 0; j < 16; j++) w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    a = h[0]; b = h[1]; c = h[2]; d = h[3];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7*i) % 16;     end
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      kk  = 32'(longint'($floor(x * 4294967296.0)));
      t   = a + f + kk + w[g];
      amt = sh[(i / 16) * 4 + (i % 4)];
      tmp = d;
      d   = c;
      c   = b;
      b   = b + ((t << amt) | (t >> (32 - amt)));
      a   = tmp;
    end
    h[0] = h[0] + a; h[1] = h[1] + b; h[2] = h[2] + c; h[3] = h[3] + d;
    for (int wi = 0; wi < 4; wi++)
      for (int j = 0; j < 4; j++)
        out[127 - 8*(4*wi + j) -: 8] = h[wi][8*j +: 8];
    return out;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge after acceptance.
  task automatic start(input logic [127:0] m, input logic [7:0] w, input string tag);
    check({tag, " ready before accept"}, 128'(ready), 128'(1));
    msg_in       = m;
    msg_in_width = w;
    msg_in_valid = 1'b1;
    @(negedge clock);
    msg_in_valid = 1'b0;
    msg_in       = {$urandom, $urandom, $urandom, $urandom};
    check({tag, " busy after accept"}, 128'(ready), 128'(0));
    check({tag, " valid low after accept"}, 128'(msg_out_valid), 128'(0));
  endtask

  task automatic wait_digest(input logic [127:0] exp, input int elapsed, input string tag);
    int cnt = elapsed;
    while (msg_out_valid !== 1'b1 && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    check({tag, " latency"}, 128'(cnt), 128'(65));
    check({tag, " digest"}, msg_output, exp);
    check({tag, " ready with valid"}, 128'(ready), 128'(1));
  endtask

  task automatic after_digest(input logic [127:0] exp, input string tag);
    @(negedge clock);
    check({tag, " valid one cycle"}, 128'(msg_out_valid), 128'(0));
    check({tag, " digest held"}, msg_output, exp);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (msg_out_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int n;
    logic [127:0] m;

    reset        = 1'b1;
    msg_in       = '0;
    msg_in_width = '0;
    msg_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("reset ready", 128'(ready), 128'(0));
    check("reset valid", 128'(msg_out_valid), 128'(0));
    check("reset err", 128'(err), 128'(0));
    check("reset digest", msg_output, 128'(0));
    reset = 1'b0;
    @(negedge clock);
    check("ready after reset", 128'(ready), 128'(1));

    start(128'(0), 8'd0, "empty");
    wait_digest(DIG_EMPTY, 0, "empty");
    after_digest(DIG_EMPTY, "empty");

    start(MSG_A, 8'd8, "a");
    wait_digest(DIG_A, 0, "a");
    after_digest(DIG_A, "a");

    start(MSG_ABC, 8'd24, "abc");
    wait_digest(DIG_ABC, 0, "abc");
    after_digest(DIG_ABC, "abc");

    start(MSG_MD, 8'd112, "b2b first");
    wait_digest(DIG_MD, 0, "b2b first");
    start(MSG_ABC, 8'd24, "b2b second");
    wait_digest(DIG_ABC, 0, "b2b second");
    after_digest(DIG_ABC, "b2b second");

    start(MSG_MD, 8'd112, "busy");
    repeat (20) @(negedge clock);
    msg_in       = MSG_A;
    msg_in_width = 8'd8;
    msg_in_valid = 1'b1;
    @(negedge clock);
    msg_in_valid = 1'b0;
    wait_digest(DIG_MD, 21, "busy");
    count_pulses(80, pulses);
    check("busy no extra digest", 128'(pulses), 128'(0));

    start(MSG_ABC, 8'd24, "abort");
    repeat (30) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort ready in reset", 128'(ready), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort ready after", 128'(ready), 128'(1));
    check("abort digest cleared", msg_output, 128'(0));
    count_pulses(80, pulses);
    check("abort no digest", 128'(pulses), 128'(0));
    check("abort digest still zero", msg_output, 128'(0));
    start(MSG_ABC, 8'd24, "post abort");
    wait_digest(DIG_ABC, 0, "post abort");
    after_digest(DIG_ABC, "post abort");

`ifdef MD5_WIDTH_CHECK_EN
    for (int t = 0; t < 2; t++) begin
      msg_in       = MSG_A;
      msg_in_width = (t == 0) ? 8'd13 : 8'd136;
      msg_in_valid = 1'b1;
      @(negedge clock);
      msg_in_valid = 1'b0;
      check("width err pulse", 128'(err), 128'(1));
      check("width ready stays", 128'(ready), 128'(1));
      @(negedge clock);
      check("width err one cycle", 128'(err), 128'(0));
      count_pulses(70, pulses);
      check("width no digest", 128'(pulses), 128'(0));
    end
`else
    start(MSG_A, 8'd13, "trunc");
    wait_digest(DIG_A, 0, "trunc");
    check("trunc err", 128'(err), 128'(0));
    after_digest(DIG_A, "trunc");
    m = {$urandom, $urandom, $urandom, $urandom};
    start(m, 8'd200, "saturate");
    wait_digest(md5_ref(m, 16), 0, "saturate");
    after_digest(md5_ref(m, 16), "saturate");
`endif

    for (int r = 0; r < 8; r++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      n = int'($urandom_range(0, 16));
      start(m, 8'(n * 8), "random");
      wait_digest(md5_ref(m, n), 0, "random");
      after_digest(md5_ref(m, n), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
